// File: rtl/latrnq_array_wrctl.sv
// Write controller for a bank of latrnq latch words: sequences D setup, a one-hot E
// pulse and D hold per write, and drives bulk clears through the shared RN line.
module latrnq_array_wrctl #(
  parameter int WORDS     = 8,
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int CLR_CYC   = 2,
  localparam int AW       = $clog2(WORDS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WR_VALID,
  output logic             WR_READY,
  input  logic [AW-1:0]    WR_ADDR,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             CLR_REQ,
  output logic [WIDTH-1:0] LAT_D,
  output logic [WORDS-1:0] LAT_E,
  output logic             LAT_RN,
  output logic             BUSY,
  output logic             ERR_OOR
);

  localparam int MAX_AB = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CD = (HOLD_CYC > CLR_CYC) ? HOLD_CYC : CLR_CYC;
  localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [2:0] S_RSTW  = 3'd0;
  localparam logic [2:0] S_REC   = 3'd1;
  localparam logic [2:0] S_IDLE  = 3'd2;
  localparam logic [2:0] S_SETUP = 3'd3;
  localparam logic [2:0] S_PULSE = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_CLEAR = 3'd6;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [WORDS-1:0] sel;
  logic [WORDS-1:0] sel_next;

  // Decoded enable for the requested word; an out-of-range address decodes to all zeros.
  always_comb begin
    sel_next = '0;
    for (int i = 0; i < WORDS; i++) begin
      sel_next[i] = (WR_ADDR == AW'(i));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_RSTW;
      cnt      <= '0;
      sel      <= '0;
      LAT_D    <= '0;
      LAT_E    <= '0;
      LAT_RN   <= 1'b0;
      WR_READY <= 1'b0;
      BUSY     <= 1'b1;
      ERR_OOR  <= 1'b0;
    end else begin
      ERR_OOR <= 1'b0;
      case (state)
        S_RSTW: begin
          LAT_RN <= 1'b1;
          state  <= S_REC;
        end
        // One cycle with RN high and E low before any enable may rise.
        S_REC: begin
          state    <= S_IDLE;
          WR_READY <= 1'b1;
          BUSY     <= 1'b0;
        end
        S_IDLE: begin
          if (CLR_REQ) begin
            LAT_RN   <= 1'b0;
            cnt      <= CW'(CLR_CYC - 1);
            state    <= S_CLEAR;
            WR_READY <= 1'b0;
            BUSY     <= 1'b1;
          end else if (WR_VALID) begin
            LAT_D    <= WR_DATA;
            sel      <= sel_next;
            ERR_OOR  <= ~|sel_next;
            cnt      <= CW'(SETUP_CYC - 1);
            state    <= S_SETUP;
            WR_READY <= 1'b0;
            BUSY     <= 1'b1;
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            LAT_E <= sel;
            cnt   <= CW'(PULSE_CYC - 1);
            state <= S_PULSE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_PULSE: begin
          if (cnt == '0) begin
            LAT_E <= '0;
            cnt   <= CW'(HOLD_CYC - 1);
            state <= S_HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            state    <= S_IDLE;
            WR_READY <= 1'b1;
            BUSY     <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_CLEAR: begin
          if (cnt == '0) begin
            LAT_RN <= 1'b1;
            state  <= S_REC;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state    <= S_RSTW;
          LAT_E    <= '0;
          LAT_RN   <= 1'b0;
          WR_READY <= 1'b0;
          BUSY     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latrnq_array_wrctl.sv
// Scoreboard bench for latrnq_array_wrctl (WORDS=6 so out-of-range addresses exist):
// the driver queues transaction-level expectations, a negedge monitor pops and compares.
module tb_latrnq_array_wrctl;

  localparam int WORDS = 6;
  localparam int WIDTH = 8;
  localparam int SC = 1, PC = 2, HC = 1, CC = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_valid;
  logic             wr_ready;
  logic [2:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             clr_req;
  logic [WIDTH-1:0] lat_d;
  logic [WORDS-1:0] lat_e;
  logic             lat_rn;
  logic             busy;
  logic             err_oor;

  latrnq_array_wrctl #(
    .WORDS(WORDS), .WIDTH(WIDTH), .SETUP_CYC(SC), .PULSE_CYC(PC), .HOLD_CYC(HC), .CLR_CYC(CC)
  ) dut (
    .CLK(clk), .RST(rst), .WR_VALID(wr_valid), .WR_READY(wr_ready), .WR_ADDR(wr_addr),
    .WR_DATA(wr_data), .CLR_REQ(clr_req), .LAT_D(lat_d), .LAT_E(lat_e), .LAT_RN(lat_rn),
    .BUSY(busy), .ERR_OOR(err_oor)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int idx; logic [WIDTH-1:0] d; int rise; int fall; } pulse_t;
  typedef struct { int c; logic [WIDTH-1:0] d; } rdy_t;

  pulse_t pq[$];
  rdy_t   rq[$];
  int     errq[$];
  int     rnfq[$];
  int     rnrq[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic [WIDTH-1:0] last_d;
  bit mon_active;

  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  task automatic wait_ready(output bit ok);
    int n = 0;
    ok = 1'b1;
    while (!wr_ready) begin
      @(negedge clk);
      n++;
      if (n > 40) begin
        chk("ready_timeout", 0, 1);
        ok = 1'b0;
        return;
      end
    end
  endtask

  // Issue one write (optionally together with a clear request that must win first).
  task automatic do_write(input logic [2:0] a, input logic [WIDTH-1:0] d, input bit with_clr);
    bit ok;
    int c;
    int acc;
    pulse_t p;
    wait_ready(ok);
    if (!ok) return;
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    clr_req  = with_clr;
    if (with_clr) begin
      c = cyc + 1;
      rnfq.push_back(c);
      rnrq.push_back(c + CC);
      rq.push_back('{c + CC + 1, last_d});
      @(negedge clk);
      clr_req = 1'b0;
      wait_ready(ok);
      if (!ok) return;
    end
    acc = cyc + 1;
    if (int'(a) < WORDS) begin
      p = '{int'(a), d, acc + SC, acc + SC + PC};
      pq.push_back(p);
    end else begin
      errq.push_back(acc);
    end
    rq.push_back('{acc + SC + PC + HC, d});
    last_d = d;
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    rnrq.push_back(cyc + 1);
    rq.push_back('{cyc + 2, '0});
    last_d = '0;
  endtask

  // Monitor: every negedge, detect output events and compare with the queued expectations.
  initial begin
    pulse_t cur;
    bit dbad;
    logic [WORDS-1:0] pe;
    logic prn, prdy;
    mon_active = 1'b0; dbad = 1'b0; pe = '0; prn = 1'b0; prdy = 1'b0;
    cur = '{0, '0, 0, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_active = 1'b0;
      end else begin
        if (lat_e != '0 && !lat_rn) chk("e_while_rn_low", lat_e, 0);
        if (pe == '0 && lat_e != '0) begin
          if (pq.size() == 0) chk("unexpected_e_pulse", lat_e, 0);
          else begin
            cur = pq.pop_front();
            mon_active = 1'b1;
            dbad = 1'b0;
            chk("e_rise_cycle", cyc, cur.rise);
            chk("e_onehot", lat_e, 1 << cur.idx);
            chk("d_at_e_rise", lat_d, cur.d);
          end
        end else if (pe != '0 && lat_e != '0 && mon_active) begin
          if (lat_e != pe || lat_d != cur.d) dbad = 1'b1;
        end else if (pe != '0 && lat_e == '0 && mon_active) begin
          chk("e_fall_cycle", cyc, cur.fall);
          chk("d_at_e_fall", lat_d, cur.d);
          chk("d_e_stable_in_pulse", dbad, 0);
          mon_active = 1'b0;
        end
        if (err_oor) begin
          if (errq.size() == 0) chk("unexpected_err_oor", 1, 0);
          else chk("err_oor_cycle", cyc, errq.pop_front());
        end
        if (prn && !lat_rn) begin
          if (rnfq.size() == 0) chk("unexpected_rn_fall", cyc, 0);
          else chk("rn_fall_cycle", cyc, rnfq.pop_front());
        end
        if (!prn && lat_rn) begin
          if (rnrq.size() == 0) chk("unexpected_rn_rise", cyc, 0);
          else chk("rn_rise_cycle", cyc, rnrq.pop_front());
          chk("e_at_rn_rise", lat_e, 0);
        end
        if (!prdy && wr_ready) begin
          rdy_t r;
          if (rq.size() == 0) chk("unexpected_ready", cyc, 0);
          else begin
            r = rq.pop_front();
            chk("ready_cycle", cyc, r.c);
            chk("d_at_ready", lat_d, r.d);
            chk("busy_at_ready", busy, 0);
          end
        end
      end
      pe = lat_e; prn = lat_rn; prdy = wr_ready;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0; last_d = '0;
    #1;
    chk("rst_lat_rn", lat_rn, 0);
    chk("rst_lat_e", lat_e, 0);
    chk("rst_lat_d", lat_d, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_err_oor", err_oor, 0);
    @(negedge clk);
    release_reset();

    // Directed cases: single write, back-to-back, clear vs pending write, out-of-range.
    do_write(3'd3, 8'hA5, 1'b0);
    wr_valid = 1'b0;
    @(negedge clk);
    do_write(3'd0, 8'h11, 1'b0);
    do_write(3'd5, 8'hFE, 1'b0);
    do_write(3'd2, 8'h3C, 1'b1);
    do_write(3'd7, 8'h5A, 1'b0);
    do_write(3'd6, 8'hC3, 1'b0);
    wr_valid = 1'b0;

    // Reset during the E pulse: outputs must drop before the next clock edge.
    do_write(3'd4, 8'h77, 1'b0);
    wr_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("e_before_mid_rst", lat_e, 1 << 4);
    #1;
    rst = 1'b1;
    pq.delete(); rq.delete(); errq.delete(); rnfq.delete(); rnrq.delete();
    #1;
    chk("midrst_lat_e", lat_e, 0);
    chk("midrst_lat_rn", lat_rn, 0);
    chk("midrst_lat_d", lat_d, 0);
    chk("midrst_ready", wr_ready, 0);
    chk("midrst_busy", busy, 1);
    repeat (2) @(negedge clk);
    release_reset();

    for (int i = 0; i < 40; i++) begin
      logic [2:0] a;
      logic [WIDTH-1:0] d;
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom_range(0, 255));
      do_write(a, d, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) begin
        wr_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    wr_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("left_e_pulses", pq.size(), 0);
    chk("left_ready_events", rq.size(), 0);
    chk("left_err_events", errq.size(), 0);
    chk("left_rn_fall_events", rnfq.size(), 0);
    chk("left_rn_rise_events", rnrq.size(), 0);
    chk("pulse_still_open", mon_active, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
